// File: rtl/alu_pkg.sv
// Shared constants for the parametrised MIPS EX-stage ALU: operation select codes
// and the multiply/divide engine state encoding.
package alu_pkg;

    localparam logic [2:0] SIG_AND   = 3'b000;
    localparam logic [2:0] SIG_OR    = 3'b001;
    localparam logic [2:0] SIG_ADD   = 3'b010;
    localparam logic [2:0] SIG_MULTU = 3'b011;
    localparam logic [2:0] SIG_DIVU  = 3'b100;
    localparam logic [2:0] SIG_RSVD  = 3'b101;
    localparam logic [2:0] SIG_SUB   = 3'b110;
    localparam logic [2:0] SIG_SLT   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_md_op(input logic [2:0] sig);
        return (sig == SIG_MULTU) || (sig == SIG_DIVU);
    endfunction

endpackage

// File: rtl/alu_param_md_if.sv
// Operand/result/handshake bundle between the control side and the ALU.
interface alu_param_md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       SIG;
    logic             start;
    logic [WIDTH-1:0] dataOut;
    logic             Zero;
    logic             Ovf;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output A, B, SIG, start,
        input  dataOut, Zero, Ovf, busy, done, hi, lo
    );

    modport slave (
        input  A, B, SIG, start,
        output dataOut, Zero, Ovf, busy, done, hi, lo
    );

endinterface

// File: rtl/alu_md_engine.sv
// Sequential unsigned multiply (shift-add) / divide (restoring) engine writing HI/LO.
// One iteration per cycle; WIDTH iterations per op, divide-by-zero short-circuits to DONE.
module alu_md_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;   // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   r_opnd;  // multiplicand or divisor
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_rem_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_step_acc;

    assign busy     = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign done     = (r_state == ST_DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign w_accept = start && !busy && is_md_op(op);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
        if (r_acc[0]) begin
            w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_mul_acc = {1'b0, r_acc[2*WIDTH-1:1]};
        end

        // Remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
        // and the top bit of the difference is the borrow.
        w_div_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff   = w_div_rem_sh - {1'b0, r_opnd};
        if (!w_div_diff[WIDTH]) begin
            w_div_acc = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_acc = {w_div_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end

        w_step_acc = (r_state == ST_DIV) ? w_div_acc : w_mul_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (op == SIG_MULTU) begin
                            r_acc   <= {{WIDTH{1'b0}}, B};
                            r_opnd  <= A;
                            r_state <= ST_MUL;
                        end else if (B == '0) begin
                            r_hi    <= A;
                            r_lo    <= '1;
                            r_state <= ST_DONE;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, A};
                            r_opnd  <= B;
                            r_state <= ST_DIV;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_step_acc[2*WIDTH-1:WIDTH];
                        r_lo    <= w_step_acc[WIDTH-1:0];
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_param_md.sv
// WIDTH-bit EX-stage ALU: zero-latency logic/add/sub/slt path plus a multi-cycle
// unsigned multiply/divide engine driving HI/LO.
module alu_param_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          rst,
    alu_param_md_if.slave io_bus
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf_raw;
    logic [WIDTH-1:0] w_result;

    // SLT shares the subtractor; its sign is corrected by the overflow bit.
    assign w_sub      = (io_bus.SIG == SIG_SUB) || (io_bus.SIG == SIG_SLT);
    assign w_b_eff    = io_bus.B ^ {WIDTH{w_sub}};
    assign w_carry[0] = w_sub;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_ripple
        assign w_sum[i]       = io_bus.A[i] ^ w_b_eff[i] ^ w_carry[i];
        assign w_carry[i + 1] = (io_bus.A[i] & w_b_eff[i]) | (io_bus.A[i] & w_carry[i]) |
                                (w_b_eff[i] & w_carry[i]);
    end

    assign w_ovf_raw = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_comb begin
        w_result = '0;
        case (io_bus.SIG)
            SIG_AND:          w_result = io_bus.A & io_bus.B;
            SIG_OR:           w_result = io_bus.A | io_bus.B;
            SIG_ADD, SIG_SUB: w_result = w_sum;
            SIG_SLT:          w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf_raw};
            SIG_MULTU, SIG_DIVU, SIG_RSVD: w_result = '0;
            default:          w_result = '0;
        endcase
    end

    assign io_bus.dataOut = w_result;
    assign io_bus.Zero    = (w_result == '0);
    assign io_bus.Ovf     = ((io_bus.SIG == SIG_ADD) || (io_bus.SIG == SIG_SUB)) && w_ovf_raw;

    alu_md_engine #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_engine (
        .clk   (clk),
        .rst   (rst),
        .start (io_bus.start),
        .op    (io_bus.SIG),
        .A     (io_bus.A),
        .B     (io_bus.B),
        .busy  (io_bus.busy),
        .done  (io_bus.done),
        .hi    (io_bus.hi),
        .lo    (io_bus.lo)
    );

endmodule

// File: tb/tb_alu_param_md.sv
// Bench for alu_param_md: vector table for the combinational path, scoreboard for HI/LO.
module tb_alu_param_md;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [2:0]   sig;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         z;
        logic         v;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_param_md_if #(.WIDTH(W)) bus ();

    alu_param_md #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;
    logic [63:0] last_e;
    vec_t        vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h with no op pending",
                         bus.hi, bus.lo);
            end else begin
                sb_exp = sb.pop_front();
                check("hi_lo", {bus.hi, bus.lo}, sb_exp);
            end
        end
    end

    task automatic do_op(input logic [2:0] sig, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_busy);
        int          nb;
        bit          seen;
        logic [63:0] e;
        if (sig == SIG_MULTU) e = {32'd0, a} * {32'd0, b};
        else if (b == 0)      e = {a, 32'hFFFF_FFFF};
        else                  e = {a % b, a / b};
        @(negedge clk);
        bus.SIG = sig; bus.A = a; bus.B = b; bus.start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.SIG = SIG_AND;
        nb = 0;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) nb++;
                @(negedge clk);
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(nb), 64'(exp_busy));
        check("busy_in_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("done_pulse_width", 64'(bus.done), 64'd0);
        last_e = e;
    endtask

    initial begin
        int  nd;
        bit  seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.SIG = SIG_AND;

        vecs[0]  = '{SIG_ADD,   32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
        vecs[1]  = '{SIG_SUB,   32'd7,         32'd7,         32'd0,         1'b1, 1'b0};
        vecs[2]  = '{SIG_ADD,   32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{SIG_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
        vecs[4]  = '{SIG_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
        vecs[5]  = '{SIG_SLT,   32'h8000_0000, 32'd1,         32'd1,         1'b0, 1'b0};
        vecs[6]  = '{SIG_SLT,   32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b1, 1'b0};
        vecs[7]  = '{SIG_SUB,   32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[8]  = '{SIG_SUB,   32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[9]  = '{SIG_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        vecs[10] = '{SIG_OR,    32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, 1'b0, 1'b0};
        vecs[11] = '{SIG_RSVD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
        vecs[12] = '{SIG_MULTU, 32'd1234,      32'd5678,      32'd0,         1'b1, 1'b0};
        vecs[13] = '{SIG_DIVU,  32'd9,         32'd3,         32'd0,         1'b1, 1'b0};
        vecs[14] = '{SIG_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
        vecs[15] = '{SIG_ADD,   32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.SIG = vecs[i].sig; bus.A = vecs[i].a; bus.B = vecs[i].b;
            #1;
            check($sformatf("vec%0d", i), {30'd0, bus.dataOut, bus.Zero, bus.Ovf},
                  {30'd0, vecs[i].y, vecs[i].z, vecs[i].v});
        end

        do_op(SIG_MULTU, 32'hFFFF_FFFF, 32'd2, 32);
        do_op(SIG_DIVU, 32'd100, 32'd7, 32);
        do_op(SIG_DIVU, 32'd9, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            do_op(SIG_MULTU, $urandom, $urandom, 32);
            do_op(SIG_DIVU, $urandom, $urandom_range(1, 1000), 32);
        end
        repeat (5) @(negedge clk);
        check("hold_hilo", {bus.hi, bus.lo}, last_e);

        // Abort a MULTU partway through with reset.
        @(negedge clk);
        bus.SIG = SIG_MULTU; bus.A = 32'd1234; bus.B = 32'd5678; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        do_op(SIG_MULTU, 32'd3, 32'd4, 32);

        // Start while busy is ignored.
        @(negedge clk);
        bus.SIG = SIG_MULTU; bus.A = 32'd5; bus.B = 32'd6; bus.start = 1'b1;
        sb.push_back(64'd30);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.SIG = SIG_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.SIG = SIG_ADD; bus.A = 32'd5; bus.B = 32'd7;
        #1;
        check("comb_while_busy", 64'(bus.dataOut), 64'd12);
        check("busy_mid_op", 64'(bus.busy), 64'd1);
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("ignored_start_dones", 64'(nd), 64'd1);

        // Back-to-back: launch the divide in the DONE cycle of the multiply.
        @(negedge clk);
        bus.SIG = SIG_MULTU; bus.A = 32'd6; bus.B = 32'd7; bus.start = 1'b1;
        sb.push_back(64'd42);
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        check("b2b_first_done", 64'(seen), 64'd1);
        bus.SIG = SIG_DIVU; bus.A = 32'd42; bus.B = 32'd5; bus.start = 1'b1;
        sb.push_back({32'd2, 32'd8});
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_done_low", 64'(bus.done), 64'd0);
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        check("b2b_second_done", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
